// File: rtl/uart_instr_fetcher.sv
// Fetches one 16-bit instruction over the shared UART: sends REQ_CMD and the PC, then assembles {hi,lo}.
// Optional macro FETCH_TIMEOUT_EN adds a per-state wait timer with request retries and an error pulse.
module uart_instr_fetcher #(
   parameter logic [7:0] REQ_CMD = 8'h03
`ifdef FETCH_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int MAX_RETRY      = 3
`endif
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  address,
   input  logic        stop_for_rw,
   input  logic        rx_done,
   input  logic [7:0]  rx_data,
   input  logic        tx_done,
   output logic        tx_start_out,
   output logic [7:0]  tx_data_out,
   output logic [15:0] instruction_out,
   output logic        done_out,
   output logic        busy,
   output logic        error
);

   typedef enum logic [2:0] {
      IDLE, SEND_CMD, WAIT_CMD, SEND_ADDR, WAIT_ADDR, RX_HI, RX_LO, DONE
   } state_t;

   state_t     state;
   logic [7:0] addr_q;
   logic [7:0] hi_q;

   assign busy = (state != IDLE);

`ifdef FETCH_TIMEOUT_EN
   logic [15:0] timer;
   logic [7:0]  retry;
   logic        in_wait;
   logic        progress;
   logic        timeout_hit;

   // A state that is about to advance never times out in the same cycle.
   always_comb begin
      in_wait     = (state == WAIT_CMD) || (state == WAIT_ADDR) ||
                    (state == RX_HI)    || (state == RX_LO);
      progress    = ((state == WAIT_CMD || state == WAIT_ADDR) && tx_done) ||
                    ((state == RX_HI    || state == RX_LO)     && rx_done);
      timeout_hit = in_wait && !progress && (timer == 16'(TIMEOUT_CYCLES - 1));
   end

   always_ff @(posedge clk) begin
      if (reset || !in_wait || progress || timeout_hit)
         timer <= '0;
      else
         timer <= timer + 16'd1;
   end
`else
   assign error = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         addr_q          <= '0;
         hi_q            <= '0;
         tx_start_out    <= 1'b0;
         tx_data_out     <= '0;
         instruction_out <= '0;
         done_out        <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
         error           <= 1'b0;
         retry           <= '0;
`endif
      end else begin
         tx_start_out <= 1'b0;
         done_out     <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
         error        <= 1'b0;
`endif
         case (state)
            IDLE: if (start) begin
               addr_q <= address;
               state  <= SEND_CMD;
            end
            SEND_CMD: if (!stop_for_rw) begin
               tx_start_out <= 1'b1;
               tx_data_out  <= REQ_CMD;
               state        <= WAIT_CMD;
            end
            WAIT_CMD: if (tx_done) state <= SEND_ADDR;
            SEND_ADDR: if (!stop_for_rw) begin
               tx_start_out <= 1'b1;
               tx_data_out  <= addr_q;
               state        <= WAIT_ADDR;
            end
            // The hi byte may arrive in the same cycle the address byte completes.
            WAIT_ADDR: if (tx_done) begin
               if (rx_done) begin
                  hi_q  <= rx_data;
                  state <= RX_LO;
               end else begin
                  state <= RX_HI;
               end
            end
            RX_HI: if (rx_done) begin
               hi_q  <= rx_data;
               state <= RX_LO;
            end
            RX_LO: if (rx_done) begin
               instruction_out <= {hi_q, rx_data};
               done_out        <= 1'b1;
               state           <= DONE;
`ifdef FETCH_TIMEOUT_EN
               retry           <= '0;
`endif
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
`ifdef FETCH_TIMEOUT_EN
         if (timeout_hit) begin
            if (retry < 8'(MAX_RETRY)) begin
               retry <= retry + 8'd1;
               state <= SEND_CMD;
            end else begin
               error <= 1'b1;
               retry <= '0;
               state <= IDLE;
            end
         end
`endif
      end
   end

endmodule
